// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the datapath widths, the one-hot op code bit positions used by both
// the alu and the arbiter, the response slot state type and the registered
// response record.
package alu_arbiter_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned OP_WIDTH   = 12;

    // One-hot op code bit positions
    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_AND  = 2;
    localparam int unsigned OP_OR   = 3;
    localparam int unsigned OP_NOR  = 4;
    localparam int unsigned OP_XOR  = 5;
    localparam int unsigned OP_SLT  = 6;
    localparam int unsigned OP_SLTU = 7;
    localparam int unsigned OP_SLL  = 8;
    localparam int unsigned OP_SRL  = 9;
    localparam int unsigned OP_SRA  = 10;
    localparam int unsigned OP_LUI  = 11;

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } slot_state_e;

    typedef struct packed {
        logic                  id;
        logic [DATA_WIDTH-1:0] result;
        logic                  zero;
        logic                  overflow;
        logic                  carry_out;
        logic                  err;
    } resp_t;

    // True when exactly one bit of the op code is set
    function automatic logic is_onehot(input logic [OP_WIDTH-1:0] op);
        logic [OP_WIDTH-1:0] op_m1;
        op_m1 = op - {{(OP_WIDTH-1){1'b0}}, 1'b1};
        return (op != '0) && ((op & op_m1) == '0);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by a one-hot op code.
// Ports:
//   a_i, b_i       operands
//   alu_op_i       one-hot op code (add, sub, and, or, nor, xor, slt, sltu,
//                  sll, srl, sra, lui at bits 0..11)
//   result_o       operation result
//   zero_o         result is all zeros
//   overflow_o     signed overflow (add/sub only)
//   carry_out_o    carry out of add, borrow out of sub
// Shifts move b_i by a_i[4:0]; lui places b_i[15:0] in the upper half.
// A non one-hot op code ORs the selected results together; callers that can
// see such codes must mask the outputs themselves.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [OP_WIDTH-1:0]   alu_op_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  overflow_o,
    output logic                  carry_out_o
);

    logic [DATA_WIDTH:0]          add_w;
    logic [DATA_WIDTH:0]          sub_w;
    logic                         add_ovf;
    logic                         sub_ovf;
    logic                         slt_bit;
    logic                         sltu_bit;
    logic [4:0]                   shamt;
    logic signed [DATA_WIDTH-1:0] sra_w;

    assign add_w    = {1'b0, a_i} + {1'b0, b_i};
    // MSB of the extended difference is the borrow
    assign sub_w    = {1'b0, a_i} - {1'b0, b_i};
    assign add_ovf  = (a_i[DATA_WIDTH-1] == b_i[DATA_WIDTH-1]) &&
                      (add_w[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
    assign sub_ovf  = (a_i[DATA_WIDTH-1] != b_i[DATA_WIDTH-1]) &&
                      (sub_w[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
    assign slt_bit  = $signed(a_i) < $signed(b_i);
    assign sltu_bit = a_i < b_i;
    assign shamt    = a_i[4:0];
    assign sra_w    = $signed(b_i) >>> shamt;

    always_comb begin
        result_o = '0;
        if (alu_op_i[OP_ADD])  result_o = result_o | add_w[DATA_WIDTH-1:0];
        if (alu_op_i[OP_SUB])  result_o = result_o | sub_w[DATA_WIDTH-1:0];
        if (alu_op_i[OP_AND])  result_o = result_o | (a_i & b_i);
        if (alu_op_i[OP_OR])   result_o = result_o | (a_i | b_i);
        if (alu_op_i[OP_NOR])  result_o = result_o | ~(a_i | b_i);
        if (alu_op_i[OP_XOR])  result_o = result_o | (a_i ^ b_i);
        if (alu_op_i[OP_SLT])  result_o = result_o | {{(DATA_WIDTH-1){1'b0}}, slt_bit};
        if (alu_op_i[OP_SLTU]) result_o = result_o | {{(DATA_WIDTH-1){1'b0}}, sltu_bit};
        if (alu_op_i[OP_SLL])  result_o = result_o | (b_i << shamt);
        if (alu_op_i[OP_SRL])  result_o = result_o | (b_i >> shamt);
        if (alu_op_i[OP_SRA])  result_o = result_o | sra_w;
        if (alu_op_i[OP_LUI])  result_o = result_o | {b_i[15:0], 16'h0000};
    end

    assign overflow_o  = (alu_op_i[OP_ADD] & add_ovf) | (alu_op_i[OP_SUB] & sub_ovf);
    assign carry_out_o = (alu_op_i[OP_ADD] & add_w[DATA_WIDTH]) |
                         (alu_op_i[OP_SUB] & sub_w[DATA_WIDTH]);
    assign zero_o      = (result_o == '0);

endmodule

// File: rtl/alu_rr_grant.sv
// Two-port arbiter and op code check for the shared ALU.
// Ports:
//   valid_i     request valids, bit N for port N
//   last_id_i   port that won the most recent accepted handshake
//   op0_i/op1_i op codes of the two ports
//   grant_o     one-hot grant, or zero when nobody is valid
//   op_err_o    granted op code is not one-hot
// FIXED_PRIO = 1 lets port 0 win every tie; otherwise a tie goes to the port
// that did not win last time.
module alu_rr_grant
    import alu_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0]          valid_i,
    input  logic                last_id_i,
    input  logic [OP_WIDTH-1:0] op0_i,
    input  logic [OP_WIDTH-1:0] op1_i,
    output logic [1:0]          grant_o,
    output logic                op_err_o
);

    logic [OP_WIDTH-1:0] granted_op;

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (FIXED_PRIO || last_id_i) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    assign granted_op = grant_o[1] ? op1_i : op0_i;
    assign op_err_o   = (|grant_o) & ~is_onehot(granted_op);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between two valid/ready requesters.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   reqN_valid / reqN_ready      request handshake for port N
//   reqN_A, reqN_B, reqN_ALUop   operands and one-hot op code of port N
//   resp_valid / resp_ready      response handshake
//   resp_id                      port that owns the response
//   resp_Result, resp_Zero,
//   resp_Overflow, resp_CarryOut registered alu outputs
//   resp_err                     the accepted op code was not one-hot
// One registered response slot; a new request is accepted whenever the slot
// is empty or being drained in the same cycle.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_A,
    input  logic [DATA_WIDTH-1:0] req0_B,
    input  logic [OP_WIDTH-1:0]   req0_ALUop,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_A,
    input  logic [DATA_WIDTH-1:0] req1_B,
    input  logic [OP_WIDTH-1:0]   req1_ALUop,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [DATA_WIDTH-1:0] resp_Result,
    output logic                  resp_Zero,
    output logic                  resp_Overflow,
    output logic                  resp_CarryOut,
    output logic                  resp_err
);

    slot_state_e           state_q, state_d;
    resp_t                 resp_q, resp_d;
    logic                  last_id_q, last_id_d;

    logic [1:0]            grant;
    logic                  op_err;
    logic                  can_accept;
    logic                  accept;

    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_overflow;
    logic                  alu_carry_out;

    alu_rr_grant #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_grant (
        .valid_i   ({req1_valid, req0_valid}),
        .last_id_i (last_id_q),
        .op0_i     (req0_ALUop),
        .op1_i     (req1_ALUop),
        .grant_o   (grant),
        .op_err_o  (op_err)
    );

    assign can_accept = (state_q == StEmpty) | resp_ready;
    // Gating with resetn keeps both readies low for the whole reset window
    assign req0_ready = grant[0] & can_accept & resetn;
    assign req1_ready = grant[1] & can_accept & resetn;
    assign accept     = req0_ready | req1_ready;

    // Idle ALU inputs are forced to zero so nothing toggles without a grant
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (grant[0]) begin
            alu_a  = req0_A;
            alu_b  = req0_B;
            alu_op = req0_ALUop;
        end else if (grant[1]) begin
            alu_a  = req1_A;
            alu_b  = req1_B;
            alu_op = req1_ALUop;
        end
    end

    alu u_alu (
        .a_i         (alu_a),
        .b_i         (alu_b),
        .alu_op_i    (alu_op),
        .result_o    (alu_result),
        .zero_o      (alu_zero),
        .overflow_o  (alu_overflow),
        .carry_out_o (alu_carry_out)
    );

    // Slot state and response capture
    always_comb begin
        state_d   = state_q;
        resp_d    = resp_q;
        last_id_d = last_id_q;

        case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (resp_ready && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase

        if (accept) begin
            last_id_d = grant[1];
            resp_d.id = grant[1];
            if (op_err) begin
                resp_d.result    = '0;
                resp_d.zero      = 1'b1;
                resp_d.overflow  = 1'b0;
                resp_d.carry_out = 1'b0;
                resp_d.err       = 1'b1;
            end else begin
                resp_d.result    = alu_result;
                resp_d.zero      = alu_zero;
                resp_d.overflow  = alu_overflow;
                resp_d.carry_out = alu_carry_out;
                resp_d.err       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StEmpty;
            resp_q    <= '0;
            last_id_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            resp_q    <= resp_d;
            last_id_q <= last_id_d;
        end
    end

    assign resp_valid    = (state_q == StFull);
    assign resp_id       = resp_q.id;
    assign resp_Result   = resp_q.result;
    assign resp_Zero     = resp_q.zero;
    assign resp_Overflow = resp_q.overflow;
    assign resp_CarryOut = resp_q.carry_out;
    assign resp_err      = resp_q.err;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between two requesters (port 0 and port 1) using valid/ready handshakes. Each accepted request drives the ALU for exactly one cycle. The ALU outputs are captured into a single registered response slot, tagged with the requester id, and held until the consumer takes them. This block sits between the issue stage of the multi-issue core and the shared ALU, and is the only driver of that ALU's inputs.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin arbitration; 1 makes port 0 always win.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request present on the port.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when both valid and ready are high.
- `req0_A`, `req0_B` / `req1_A`, `req1_B`  in  32  operands.
- `req0_ALUop` / `req1_ALUop`  in  12  one-hot op code, using the same bit order as `alu`: add, sub, and, or, nor, xor, slt, sltu, sll, srl, sra, lui at bits 0..11.
- `resp_valid`  out  1  response slot occupied.
- `resp_ready`  in  1  consumer takes the response when both valid and ready are high.
- `resp_id`  out  1  requester that owns the response.
- `resp_Result`  out  32  registered ALU `Result`.
- `resp_Zero`, `resp_Overflow`, `resp_CarryOut`  out  1 each  registered ALU flags.
- `resp_err`  out  1  the op code was not one-hot.

## Operation
- Slot state machine:
  - EMPTY: `resp_valid` = 0.
  - FULL: `resp_valid` = 1.
  - EMPTY → FULL on any accept.
  - FULL → EMPTY when the response is taken and there is no accept in the same cycle.
  - FULL → FULL when the response is taken and a new request is accepted in the same cycle.
  - FULL → FULL (hold) when `resp_ready` = 0.
- `can_accept` = !`resp_valid` | `resp_ready`.
- Grant:
  - Only one requester valid: it wins.
  - Both valid with `FIXED_PRIO` = 1: port 0 wins.
  - Both valid with `FIXED_PRIO` = 0: the port not equal to `last_id` wins.
  - `reqN_ready` = grant[N] & `can_accept`. This is combinational from the valid inputs, `resp_valid` and `resp_ready`. At most one ready is high per cycle.
  - `last_id` updates to the granted id only on an accepted handshake. Its reset value is 1, so port 0 wins the first tie.
- ALU input mux: selects the granted port's A/B/ALUop. When there is no grant, it drives ALUop = 0 and A/B = 0.
- One-hot check:
  - Applies to the granted ALUop: zero set bits, or more than one set bit, is an error.
  - On error, capture `resp_err` = 1, `resp_Result` = 0, `resp_Zero` = 1, `resp_Overflow` = 0, `resp_CarryOut` = 0.
  - A request with an error is still accepted and still consumes an arbitration turn.
- Requesters must hold valid and all payload stable until accepted. This block does not check that rule.
- While FULL and not taken, every `resp_*` output stays stable, bit for bit.

## Timing
- Latency: request accepted in cycle N → `resp_valid` = 1 with its data in cycle N+1.
- Throughput: one operation per cycle while `resp_ready` stays high and at least one requester is valid.
- Fairness: with both ports continuously valid and `FIXED_PRIO` = 0, grants alternate strictly 0,1,0,1…
- Back-pressure: while FULL and `resp_ready` = 0, both `reqN_ready` = 0.
- Reset values, applied asynchronously on `resetn` = 0 regardless of the clock:
  - `resp_valid`, `resp_id`, `resp_Result`, `resp_Zero`, `resp_Overflow`, `resp_CarryOut`, `resp_err` = 0.
  - `last_id` = 1.
  - Any pending response is discarded.
- While `resetn` = 0: `req0_ready` = `req1_ready` = 0.
- First accept possible: the first rising edge after `resetn` deasserts.

## Structure
- Shared header `alu_defs.vh`:
  - `DATA_WIDTH` = 32, `OP_WIDTH` = 12.
  - Named bit indices `OP_ADD` … `OP_LUI` (0..11), used by both `alu` and this block.
- Sub-module: one instance of the existing `alu`.
- Arbitration plus the one-hot check form a natural combinational sub-module, `alu_rr_grant`. Inputs: valids, `last_id`, `FIXED_PRIO`. Outputs: grant vector, `op_err`.

## Test plan
- Single op on port 0: add, A=0x7FFFFFFF, B=0x00000001 → one cycle later `resp_valid` = 1, `resp_id` = 0, `resp_Result` = 0x80000000, `resp_Overflow` = 1, `resp_Zero` = 0.
- Zero flag on port 1: sub, A=5, B=5 → `resp_id` = 1, `resp_Result` = 0, `resp_Zero` = 1, `resp_err` = 0.
- Contention: both ports valid for 6 cycles with `resp_ready` = 1, `FIXED_PRIO` = 0 → `resp_id` sequence 0,1,0,1,0,1, one response per cycle. Repeat with `FIXED_PRIO` = 1 → all six are 0 and port 1 is never ready.
- Back-pressure: `resp_ready` = 0 for 3 cycles while FULL with lui, B=0x00001234 → `resp_Result` holds 0x12340000 and both readies stay 0. Raise `resp_ready` → the next request is accepted in that same cycle.
- Illegal op: ALUop = 0x003, then ALUop = 0x000 → each gives `resp_err` = 1, `resp_Result` = 0, `resp_Zero` = 1. The arbitration turn advances.
- Reset mid-operation: `resetn` pulled low asynchronously while FULL and held → `resp_valid` = 0 before the next edge. After release, the first tie is granted to port 0.
